// File: rtl/dcache_pkg.sv
// Shared types and helpers for the flushable data-cache storage block:
// flush sequencer states and the byte-lane merge used on partial writes.
package dcache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_READ,
        S_EMIT,
        S_DONE
    } flush_state_e;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MERGE_MAXBITS = 256;

    function automatic logic [MERGE_MAXBITS-1:0] byte_merge(
        input logic [MERGE_MAXBITS-1:0]   old_word,
        input logic [MERGE_MAXBITS-1:0]   new_word,
        input logic [MERGE_MAXBITS/8-1:0] byte_en
    );
        logic [MERGE_MAXBITS-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < MERGE_MAXBITS / 8; i++) begin
            if (byte_en[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/spram_be.sv
// Single-port byte-enable RAM. Read is combinational from the array, so the
// data seen in a write cycle is the pre-write word (read-first).
module spram_be
    import dcache_pkg::*;
#(
    parameter int DATABITS = 32,
    parameter int MEMSIZE  = 32,
    localparam int AW      = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DATABITS/8-1:0] be,
    input  logic [AW-1:0]         addr,
    input  logic [DATABITS-1:0]   wdata,
    output logic [DATABITS-1:0]   rdata
);

    logic [DATABITS-1:0] mem_q [MEMSIZE];

    // Storage is deliberately not reset so contents survive a block reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= DATABITS'(byte_merge(MERGE_MAXBITS'(mem_q[addr]),
                                                MERGE_MAXBITS'(wdata),
                                                (MERGE_MAXBITS/8)'(be)));
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/dcache_flushblock.sv
// Cache data store with per-word dirty tracking and a flush sequencer that
// walks the array and writes back dirty words over a valid/ready interface.
module dcache_flushblock
    import dcache_pkg::*;
#(
    parameter int DATABITS = 32,
    parameter int ADDRBITS = 5,
    parameter int MEMSIZE  = 2 ** ADDRBITS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDRBITS-1:0]   addr,
    input  logic [DATABITS-1:0]   data_in,
    input  logic [DATABITS/8-1:0] byte_en,
    input  logic                  we,
    output logic [DATABITS-1:0]   data_out,
    input  logic                  flush_start,
    output logic                  flush_busy,
    output logic                  flush_done,
    output logic [ADDRBITS-1:0]   flush_addr,
    output logic [DATABITS-1:0]   flush_data,
    output logic                  flush_valid,
    input  logic                  flush_ready,
    output logic [ADDRBITS:0]     dirty_count
);

    localparam int NBYTES = DATABITS / 8;
    localparam int RAM_AW = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
    localparam logic [ADDRBITS-1:0] PTR_LAST = ADDRBITS'(MEMSIZE - 1);

    flush_state_e          state_q, state_d;
    logic [ADDRBITS-1:0]   ptr_q, ptr_d;
    logic [MEMSIZE-1:0]    dirty_q, dirty_d;
    logic [ADDRBITS:0]     dirty_count_q, dirty_count_d;
    logic [DATABITS-1:0]   data_out_q, data_out_d;
    logic [DATABITS-1:0]   flush_data_q, flush_data_d;

    logic                  busy;
    logic                  core_hit;
    logic                  core_wr;
    logic [RAM_AW-1:0]     ram_addr;
    logic                  ram_we;
    logic [NBYTES-1:0]     ram_be;
    logic [DATABITS-1:0]   ram_wdata;
    logic [DATABITS-1:0]   ram_rdata;

    spram_be #(
        .DATABITS (DATABITS),
        .MEMSIZE  (MEMSIZE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        dirty_d       = dirty_q;
        dirty_count_d = dirty_count_q;
        flush_data_d  = flush_data_q;
        flush_valid   = 1'b0;
        flush_done    = 1'b0;

        busy     = (state_q != S_IDLE);
        core_hit = int'(addr) < MEMSIZE;
        core_wr  = !busy && we && (|byte_en) && core_hit;

        // The single RAM port belongs to the sequencer whenever it is active.
        ram_addr  = RAM_AW'(busy ? ptr_q : addr);
        ram_we    = core_wr;
        ram_be    = byte_en;
        ram_wdata = data_in;

        data_out_d = busy ? data_out_q : (core_hit ? ram_rdata : '0);

        if (core_wr) begin
            dirty_d[addr] = 1'b1;
            if (!dirty_q[addr]) begin
                dirty_count_d = dirty_count_q + (ADDRBITS+1)'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (flush_start) begin
                    state_d = S_SCAN;
                    ptr_d   = '0;
                end
            end
            S_SCAN: begin
                if (dirty_q[ptr_q]) begin
                    state_d = S_READ;
                end else if (ptr_q == PTR_LAST) begin
                    state_d = S_DONE;
                end else begin
                    ptr_d = ptr_q + ADDRBITS'(1);
                end
            end
            S_READ: begin
                flush_data_d = ram_rdata;
                state_d      = S_EMIT;
            end
            S_EMIT: begin
                flush_valid = 1'b1;
                if (flush_ready) begin
                    dirty_d[ptr_q] = 1'b0;
                    dirty_count_d  = dirty_count_q - (ADDRBITS+1)'(1);
                    if (ptr_q == PTR_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SCAN;
                        ptr_d   = ptr_q + ADDRBITS'(1);
                    end
                end
            end
            S_DONE: begin
                flush_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            dirty_q       <= '0;
            dirty_count_q <= '0;
            data_out_q    <= '0;
            flush_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            dirty_q       <= dirty_d;
            dirty_count_q <= dirty_count_d;
            data_out_q    <= data_out_d;
            flush_data_q  <= flush_data_d;
        end
    end

    assign flush_busy  = busy;
    assign flush_addr  = ptr_q;
    assign flush_data  = flush_data_q;
    assign data_out    = data_out_q;
    assign dirty_count = dirty_count_q;

endmodule

// File: tb/tb_dcache_flushblock.sv
// Directed and randomized checks of dcache_flushblock against a word-array /
// dirty-set reference model.
module tb_dcache_flushblock;

    localparam int DATABITS = 32;
    localparam int ADDRBITS = 5;
    localparam int MEMSIZE  = 32;

    logic                  clk;
    logic                  reset_n;
    logic [ADDRBITS-1:0]   addr;
    logic [DATABITS-1:0]   data_in;
    logic [DATABITS/8-1:0] byte_en;
    logic                  we;
    logic [DATABITS-1:0]   data_out;
    logic                  flush_start;
    logic                  flush_busy;
    logic                  flush_done;
    logic [ADDRBITS-1:0]   flush_addr;
    logic [DATABITS-1:0]   flush_data;
    logic                  flush_valid;
    logic                  flush_ready;
    logic [ADDRBITS:0]     dirty_count;

    dcache_flushblock #(
        .DATABITS (DATABITS),
        .ADDRBITS (ADDRBITS),
        .MEMSIZE  (MEMSIZE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .addr        (addr),
        .data_in     (data_in),
        .byte_en     (byte_en),
        .we          (we),
        .data_out    (data_out),
        .flush_start (flush_start),
        .flush_busy  (flush_busy),
        .flush_done  (flush_done),
        .flush_addr  (flush_addr),
        .flush_data  (flush_data),
        .flush_valid (flush_valid),
        .flush_ready (flush_ready),
        .dirty_count (dirty_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DATABITS-1:0] mem_m   [MEMSIZE];
    bit                  dirty_m [MEMSIZE];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int dirty_pop();
        int n = 0;
        for (int i = 0; i < MEMSIZE; i++) n += dirty_m[i] ? 1 : 0;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_write(input int a, input logic [31:0] d, input logic [3:0] be, input bit chk_old);
        logic [31:0] old;
        old     = mem_m[a];
        addr    = ADDRBITS'(a);
        data_in = d;
        byte_en = be;
        we      = 1'b1;
        tick();
        we = 1'b0;
        if (chk_old) chk("read_first", data_out, old);
        if (be != 4'b0) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_m[a][8*b +: 8] = d[8*b +: 8];
            dirty_m[a] = 1'b1;
        end
    endtask

    task automatic core_read(input int a, input string tag);
        addr = ADDRBITS'(a);
        we   = 1'b0;
        tick();
        chk(tag, data_out, mem_m[a]);
    endtask

    // stall_n < 0 picks a random stall per beat; poke injects a core write to
    // addr 2 and a second flush_start while the flush is in progress.
    task automatic run_flush(input int stall_n, input bit poke);
        int          expq[$];
        bit          in_beat;
        bit          finished;
        int          stall;
        int          done_cnt;
        logic [4:0]  cap_a;
        logic [31:0] cap_d;
        in_beat  = 0;
        finished = 0;
        stall    = 0;
        done_cnt = 0;
        cap_a    = '0;
        cap_d    = '0;
        for (int a = 0; a < MEMSIZE; a++) if (dirty_m[a]) expq.push_back(a);
        flush_start = 1'b1;
        tick();
        flush_start = 1'b0;
        chk("flush_busy_start", flush_busy, 1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!flush_busy) begin
                finished = 1;
                break;
            end
            if (poke && cyc == 3) begin
                addr = 5'd2; data_in = $urandom; byte_en = 4'hF; we = 1'b1; flush_start = 1'b1;
            end else if (poke && cyc == 4) begin
                we = 1'b0; flush_start = 1'b0;
            end
            if (flush_done) done_cnt++;
            if (flush_valid) begin
                if (!in_beat) begin
                    in_beat = 1;
                    cap_a   = flush_addr;
                    cap_d   = flush_data;
                    stall   = (stall_n < 0) ? int'($urandom_range(0, 3)) : stall_n;
                    if (expq.size() > 0) begin
                        chk("wb_addr", cap_a, expq[0]);
                        chk("wb_data", cap_d, mem_m[expq[0]]);
                    end else begin
                        chk("wb_unexpected", 1, 0);
                    end
                end else begin
                    chk("wb_addr_stable", flush_addr, cap_a);
                    chk("wb_data_stable", flush_data, cap_d);
                end
                if (stall == 0) begin
                    flush_ready = 1'b1;
                    if (expq.size() > 0) begin
                        dirty_m[expq[0]] = 1'b0;
                        void'(expq.pop_front());
                    end
                    in_beat = 0;
                end else begin
                    flush_ready = 1'b0;
                    stall--;
                end
            end else begin
                flush_ready = 1'($urandom_range(0, 1));
            end
            tick();
        end
        flush_ready = 1'b0;
        chk("flush_finished", finished, 1);
        chk("flush_all_written", expq.size(), 0);
        chk("flush_done_pulses", done_cnt, 1);
        chk("flush_dirty_zero", dirty_count, 0);
        tick();
        chk("flush_stays_idle", flush_busy, 0);
    endtask

    initial begin
        int          n;
        bit          seen;
        logic [3:0]  be;
        reset_n     = 1'b0;
        addr        = '0;
        data_in     = '0;
        byte_en     = '0;
        we          = 1'b0;
        flush_start = 1'b0;
        flush_ready = 1'b0;
        for (int i = 0; i < MEMSIZE; i++) dirty_m[i] = 1'b0;
        #1;
        chk("rst_data_out", data_out, 0);
        chk("rst_busy", flush_busy, 0);
        chk("rst_valid", flush_valid, 0);
        chk("rst_done", flush_done, 0);
        chk("rst_dirty_count", dirty_count, 0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

        // Fill every word so the model is fully known; count reaches MEMSIZE.
        for (int a = 0; a < MEMSIZE; a++) core_write(a, $urandom, 4'hF, 0);
        chk("dirty_count_full", dirty_count, MEMSIZE);
        run_flush(0, 0);

        // Clean flush: pure scan then DONE.
        flush_start = 1'b1;
        tick();
        flush_start = 1'b0;
        n    = 1;
        seen = 0;
        while (!flush_done && n < 200) begin
            if (flush_valid) seen = 1;
            tick();
            n++;
        end
        chk("clean_done_latency", n, MEMSIZE + 1);
        chk("clean_no_valid", seen, 0);
        tick();
        chk("clean_idle_after", flush_busy, 0);

        core_write(3, 32'hDEADBEEF, 4'hF, 1);
        core_read(3, "rd_addr3");
        chk("rd_addr3_const", data_out, 32'hDEADBEEF);
        chk("dirty_count_one", dirty_count, 1);
        run_flush(0, 0);

        core_write(5, 32'h11223344, 4'hF, 1);
        core_write(5, 32'hAABBCCDD, 4'b0101, 1);
        core_read(5, "rd_merge");
        chk("rd_merge_const", data_out, 32'h11BB33DD);
        chk("dirty_count_merge", dirty_count, 1);
        core_write(6, $urandom, 4'b0000, 1);
        core_read(6, "rd_be_zero");
        chk("dirty_count_be_zero", dirty_count, 1);
        run_flush(0, 0);

        core_write(0, $urandom, 4'hF, 1);
        core_write(7, $urandom, 4'hF, 1);
        core_write(31, $urandom, 4'hF, 1);
        chk("dirty_count_three", dirty_count, 3);
        run_flush(10, 0);

        for (int k = 0; k < 80; k++) begin
            int a;
            a = int'($urandom_range(0, MEMSIZE - 1));
            if ($urandom_range(0, 2) == 0) begin
                core_read(a, "rand_read");
            end else begin
                be = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0) be = 4'b0;
                core_write(a, $urandom, be, 1);
            end
            chk("rand_dirty_count", dirty_count, dirty_pop());
        end
        run_flush(-1, 0);

        core_write(1, $urandom, 4'hF, 1);
        core_write(20, $urandom, 4'hF, 1);
        run_flush(4, 1);
        core_read(2, "busy_write_ignored");
        chk("busy_dirty_count", dirty_count, 0);

        // Reset while a write-back is pending.
        core_write(4, $urandom, 4'hF, 1);
        core_write(9, $urandom, 4'b1001, 1);
        flush_ready = 1'b0;
        flush_start = 1'b1;
        tick();
        flush_start = 1'b0;
        for (int i = 0; i < 100 && !flush_valid; i++) tick();
        chk("rst_reach_emit", flush_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", flush_valid, 0);
        chk("midrst_busy", flush_busy, 0);
        chk("midrst_dirty_count", dirty_count, 0);
        chk("midrst_data_out", data_out, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_done", flush_done, 0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < MEMSIZE; i++) dirty_m[i] = 1'b0;
        tick();
        chk("postrst_no_done", flush_done, 0);
        for (int a = 0; a < MEMSIZE; a++) core_read(a, "mem_retained");
        chk("postrst_dirty_count", dirty_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_flushblock.md
DCACHE_FLUSHBLOCK -- requirements
Module: dcache_flushblock

Interface
REQ-001 The block SHALL have parameter DATABITS, default 32, giving the data word width; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter ADDRBITS, default 5, giving the word address width.
REQ-003 The block SHALL have parameter MEMSIZE, default 2**ADDRBITS, giving the number of words.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port addr, input, ADDRBITS: core word address.
REQ-007 The block SHALL have port data_in, input, DATABITS: core write data.
REQ-008 The block SHALL have port byte_en, input, DATABITS/8: core write byte lanes.
REQ-009 The block SHALL have port we, input, 1 bit: core write strobe.
REQ-010 The block SHALL have port data_out, output, DATABITS: registered core read data.
REQ-011 The block SHALL have port flush_start, input, 1 bit: a single-cycle request to write back all dirty words.
REQ-012 The block SHALL have port flush_busy, output, 1 bit: the flush sequencer is active.
REQ-013 The block SHALL have port flush_done, output, 1 bit: a one-cycle pulse at the end of a flush.
REQ-014 The block SHALL have port flush_addr, output, ADDRBITS: address of the word being written back.
REQ-015 The block SHALL have port flush_data, output, DATABITS: data of the word being written back.
REQ-016 The block SHALL have port flush_valid, output, 1 bit: flush_addr and flush_data are valid.
REQ-017 The block SHALL have port flush_ready, input, 1 bit: the downstream memory accepts the write-back.
REQ-018 The block SHALL have port dirty_count, output, ADDRBITS+1: the number of dirty words.

Function
REQ-019 A core read SHALL have 1-cycle latency: data_out SHALL carry mem[addr] in the cycle after addr is presented; when we=1, data_out SHALL carry the pre-write contents (read-first).
REQ-020 A core write with we=1 SHALL update only the byte lanes whose byte_en bit is 1, and SHALL set dirty[addr]=1.
REQ-021 A core write with we=1 and byte_en all zero SHALL be a no-op: no data change and no dirty change.
REQ-022 dirty_count SHALL increment only when a write sets a previously clean bit, SHALL decrement on each flush handshake, and SHALL be a saturating-free exact count ranging 0..MEMSIZE.
REQ-023 The flush sequencer SHALL be an FSM with states IDLE, SCAN, READ, EMIT and DONE.
REQ-024 In IDLE, flush_start=1 SHALL move the FSM to SCAN with ptr=0; flush_busy SHALL be 1 in every state except IDLE.
REQ-025 In SCAN, the FSM SHALL evaluate one word per cycle: if dirty[ptr]=1 it SHALL go to READ; otherwise, if ptr=MEMSIZE-1 it SHALL go to DONE, else ptr SHALL increment.
REQ-026 In READ, the block SHALL issue a memory read of ptr and SHALL then move to EMIT.
REQ-027 In EMIT, flush_valid SHALL be 1, with flush_addr=ptr and flush_data held stable until flush_ready=1.
REQ-028 On a flush handshake (flush_valid and flush_ready both 1), dirty[ptr] SHALL be cleared; the FSM SHALL then go to DONE if ptr=MEMSIZE-1, otherwise to SCAN with ptr+1.
REQ-029 In DONE, flush_done SHALL be 1 for exactly one cycle and the FSM SHALL then return to IDLE.
REQ-030 While flush_busy=1, core writes SHALL be ignored and data_out SHALL hold its last value; flush_start while busy SHALL be ignored.
REQ-031 flush_valid SHALL never deassert before a handshake; a write-back stall of any length SHALL be tolerated.
REQ-032 When MEMSIZE < 2**ADDRBITS, addresses at or above MEMSIZE SHALL be ignored on writes and SHALL return 0 on reads.

Reset
REQ-033 reset_n=0 SHALL asynchronously force the FSM to IDLE, clear all dirty bits, and set ptr=0, dirty_count=0, data_out=0, flush_valid=0, flush_busy=0 and flush_done=0.
REQ-034 Reset SHALL NOT clear the memory array; a reset mid-flush SHALL abandon the flush without a flush_done pulse.

Structure
REQ-035 The FSM state enum and a byte-merge helper (old word, new word, byte_en) SHALL live in shared package dcache_pkg.
REQ-036 The storage SHALL be a single sub-module spram_be (single-port, byte-enable, read-first, parametrised by DATABITS and MEMSIZE); the core and flush accesses SHALL share its one port through a mux on flush_busy.

Verification
REQ-037 Bench: write 0xDEADBEEF to addr 3, then read addr 3 -> data_out=0xDEADBEEF one cycle later, dirty_count=1.
REQ-038 Bench: write 0x11223344 to addr 5, then write data 0xAABBCCDD with byte_en=4'b0101 to addr 5 -> read returns 0x11BB33DD, dirty_count=1.
REQ-039 Bench: on a clean block, pulse flush_start -> flush_valid never asserts, flush_done pulses exactly MEMSIZE+1 cycles after flush_start (32 SCAN + DONE at defaults).
REQ-040 Bench: dirty addresses 0, 7 and 31, hold flush_ready=0 for 10 cycles on each -> three write-backs in address order, each holding stable data, ending with dirty_count=0 and one flush_done pulse.
REQ-041 Bench: during a flush, issue a core write to addr 2 -> memory and dirty_count are unchanged; a further flush_start while busy is ignored.
REQ-042 Bench: assert reset_n=0 in EMIT -> flush_valid=0 and flush_busy=0 immediately, dirty_count=0, no flush_done pulse, and memory contents are retained.
